// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ byte clients,
// with busy tracking, busy-rise timeout and an idle gap between frames.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_start,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic                         timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  localparam state_t AFTER = (GAP_CYCLES == 0) ? IDLE : GAP;
  state_t state, next;
  logic [IW-1:0] ptr, pick;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic to_hit, gap_done;
  // First valid client at or above the pointer, wrapping; scanning downward lets the nearest win.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IW-1:0] p);
    rr_pick = p;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (v[(int'(p) + k) % NUM_REQ]) rr_pick = IW'((int'(p) + k) % NUM_REQ);
  endfunction
  assign pick     = rr_pick(req_valid, ptr);
  assign to_hit   = tcnt == TW'(BUSY_TIMEOUT - 1);
  assign gap_done = (GAP_CYCLES <= 1) || gcnt == GW'(GAP_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = |req_valid ? ISSUE : IDLE;
      ISSUE:     next = WAIT_BUSY;
      WAIT_BUSY: next = tx_busy ? WAIT_DONE : to_hit ? AFTER : WAIT_BUSY;
      WAIT_DONE: next = tx_busy ? WAIT_DONE : AFTER;
      GAP:       next = gap_done ? IDLE : GAP;
      default:   next = IDLE;
    endcase
  end
  always_comb active = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      ptr         <= '0;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      req_ready <= '0;
      tx_start  <= state == ISSUE;
      gcnt      <= state == GAP ? gcnt + 1'b1 : '0;
      if (state == IDLE && |req_valid) begin
        grant_id  <= pick;
        tx_data   <= req_data[int'(pick)*DATA_W +: DATA_W];
        req_ready <= NUM_REQ'(1) << pick;
      end
      if (state == ISSUE) begin
        ptr  <= grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        tcnt <= '0;
      end
      if (state == WAIT_BUSY && !tx_busy) begin
        if (to_hit) timeout_err <= 1'b1;
        else tcnt <= tcnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a grant/data scoreboard popped on every tx_start.
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8;
  logic clk = 0, reset = 1;
  logic [N-1:0] req_valid = '0, req_ready, v1 = '0, rdy1;
  logic [N*W-1:0] req_data = '0;
  logic tx_start, tx_busy = 0, active, timeout_err;
  logic st1, busy1 = 0, act1, err1;
  logic [W-1:0] tx_data, d1;
  logic [1:0] grant_id, g1;
  int total = 0, bad = 0, sb_e;
  int exp_q[$];

  uart_tx_arbiter u0 (.clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .timeout_err(timeout_err));
  uart_tx_arbiter #(.GAP_CYCLES(0)) u1 (.clk(clk), .reset(reset), .req_valid(v1),
    .req_data(req_data), .req_ready(rdy1), .tx_start(st1), .tx_data(d1), .tx_busy(busy1),
    .grant_id(g1), .active(act1), .timeout_err(err1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int id);
    exp_q.push_back(id * 256 + int'(req_data[id*W +: W]));
  endtask

  always @(negedge clk) if (reset) begin
    if (req_ready != '0) chk("ready_onehot", 32'($onehot(req_ready)), 1);
    if (tx_start) begin
      if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        sb_e = exp_q.pop_front();
        chk("sb_grant", 32'(grant_id), sb_e / 256);
        chk("sb_data", 32'(tx_data), sb_e % 256);
      end
    end
  end

  task automatic wait_ready(output int idx);
    idx = -1;
    for (int n = 0; n < 40 && idx < 0; n++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
    end
    if (idx < 0) chk("ready_timeout", 0, 1);
  endtask

  task automatic serve(input bit persist, input int blen);
    int idx;
    wait_ready(idx);
    if (idx >= 0) begin
      if (!persist) req_valid[idx] = 1'b0;
      @(negedge clk);
      chk("ready_single_pulse", 32'(req_ready), 0);
      chk("start_after_ready", 32'(tx_start), 1);
      tx_busy = 1;
      repeat (blen) @(negedge clk);
      tx_busy = 0;
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && active; n++) @(negedge clk);
    chk("idle_timeout", 32'(active), 0);
  endtask

  initial begin
    int idx, n;
    #2 reset = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_start", 32'(tx_start), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_active", 32'(active), 0);
    chk("rst_err", 32'(timeout_err), 0);
    reset = 1;
    @(negedge clk);
    // all four clients held valid: plain rotation from pointer 0
    req_data = 32'h44332211;
    push(0); push(1); push(2); push(3); push(0);
    req_valid = '1;
    repeat (5) serve(1, 4);
    req_valid = '0;
    wait_idle();
    // fairness: after client 3, client 0 beats 3
    push(3);
    req_valid[3] = 1;
    serve(0, 3);
    wait_idle();
    push(0); push(3);
    req_valid = 4'b1001;
    serve(0, 3);
    serve(0, 3);
    wait_idle();
    // single client 2 with exact latencies
    req_data[2*W +: W] = 8'hA5;
    push(2);
    req_valid[2] = 1;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'b0100);
    req_valid[2] = 0;
    @(negedge clk);
    chk("t1_start", 32'(tx_start), 1);
    chk("t1_data", 32'(tx_data), 32'hA5);
    chk("t1_grant", 32'(grant_id), 2);
    tx_busy = 1;
    repeat (10) @(negedge clk);
    tx_busy = 0;
    repeat (2) @(negedge clk);
    chk("t1_active_gap", 32'(active), 1);
    @(negedge clk);
    chk("t1_active_low", 32'(active), 0);
    chk("t1_data_hold", 32'(tx_data), 32'hA5);
    // busy never rises: timeout 16 cycles after tx_start
    push(1);
    req_valid[1] = 1;
    wait_ready(idx);
    req_valid[1] = 0;
    @(negedge clk);
    chk("to_start", 32'(tx_start), 1);
    repeat (15) @(negedge clk);
    chk("to_err_early", 32'(timeout_err), 0);
    @(negedge clk);
    chk("to_err_set", 32'(timeout_err), 1);
    repeat (2) @(negedge clk);
    chk("to_idle", 32'(active), 0);
    push(2);
    req_valid[2] = 1;
    serve(0, 3);
    chk("to_err_sticky", 32'(timeout_err), 1);
    wait_idle();
    // asynchronous reset in WAIT_DONE, then pointer back at 0
    push(0);
    req_valid[0] = 1;
    wait_ready(idx);
    req_valid[0] = 0;
    @(negedge clk);
    tx_busy = 1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 reset = 0;
    #1;
    chk("ar_active", 32'(active), 0);
    chk("ar_err", 32'(timeout_err), 0);
    chk("ar_data", 32'(tx_data), 0);
    chk("ar_ready_start_grant", {req_ready, tx_start, grant_id}, 0);
    tx_busy = 0;
    @(negedge clk);
    reset = 1;
    push(0); push(1);
    req_valid = 4'b0011;
    serve(0, 2);
    serve(0, 2);
    wait_idle();
    // zero-gap build: persistent client 1 re-granted one cycle after busy low is seen
    v1[1] = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy1[1] && n < 40);
    chk("g0_ready", 32'(rdy1), 32'b0010);
    @(negedge clk);
    chk("g0_start", 32'(st1), 1);
    chk("g0_data", 32'(d1), 32'h22);
    chk("g0_grant", 32'(g1), 1);
    busy1 = 1;
    repeat (5) @(negedge clk);
    busy1 = 0;
    @(negedge clk);
    chk("g0_ready_early", 32'(rdy1), 0);
    @(negedge clk);
    chk("g0_ready_next", 32'(rdy1), 32'b0010);
    v1 = '0;
    @(negedge clk);
    chk("g0_start2", 32'(st1), 1);
    busy1 = 1;
    repeat (3) @(negedge clk);
    busy1 = 0;
    for (int k = 0; k < 10 && act1; k++) @(negedge clk);
    chk("g0_idle", 32'(act1), 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end
endmodule
